sd_init_seq: RTL and testbench
==============================

// Module: sd_init_seq
// PURPOSE
//  Sequencer for the SD SPI-mode single-command engine (cmd_* / done handshake).
//  - Runs the card power-up sequence: CMD0, CMD8, CMD55/ACMD41 polling.
//  - Then serves single-block read requests with CMD17 and returns the 32-bit data word.
//  - Sits between the command engine and the host logic that consumes card data.
// PARAMETERS
//  ACMD41_RETRIES  1000   max CMD55+ACMD41 pairs before init fails
//  TIMEOUT_CYCLES  65535  max cycles waiting for cmd_done per command
// PORTS
//  clk          in   1   system clock
//  reset        in   1   asynchronous, active-high reset
//  init_start   in   1   level; rising edge while IDLE starts power-up sequence
//  ready        out  1   card initialised, read requests accepted
//  error        out  1   sticky failure flag, cleared only by reset
//  err_code     out  3   0 none, 1 CMD0, 2 CMD8, 3 ACMD41 retries, 4 timeout, 5 CMD17
//  rd_req       in   1   read request, valid only while ready=1
//  rd_addr      in   32  block address, sampled on the rd_req accept cycle
//  rd_busy      out  1   high from accept until rd_valid
//  rd_valid     out  1   one-cycle pulse, rd_data valid
//  rd_data      out  32  data word returned by the engine
//  cmd_number   out  8   to engine: 0x40|index
//  cmd_args     out  32  to engine: argument
//  cmd_crc      out  8   to engine: CRC7<<1|1
//  cmd_start    out  1   to engine: start level
//  cmd_reset    out  1   to engine: one-cycle reset pulse after a timeout
//  cmd_done     in   1   from engine
//  cmd_flags    in   8   from engine: R1 response (bit0 idle, bit2 illegal command)
//  cmd_data     in   32  from engine: read data (meaningful for CMD17 only)
// BEHAVIOUR
//  - Reset values: every output 0; state IDLE; retry and timeout counters 0.
//  - Command handshake, identical for every command:
//    - ISSUE: drive cmd_number/cmd_args/cmd_crc. Keep them stable and set cmd_start=1.
//    - WAIT_DONE: hold cmd_start until cmd_done=1, then latch cmd_flags/cmd_data in that cycle.
//    - RELEASE: cmd_start=0; wait for cmd_done=0, then go to EVAL.
//    - The timeout counter runs in WAIT_DONE and RELEASE.
//    - If it reaches TIMEOUT_CYCLES: cmd_reset=1 for one cycle, err_code=4, state ERROR.
//  - Sequence and EVAL rules:
//    - CMD0  0x40 arg 0x00000000 crc 0x95. Flags==0x01 -> CMD8, otherwise ERROR code 1.
//    - CMD8  0x48 arg 0x000001AA crc 0x87.
//      Flags==0x01 -> CMD55. Flags bit2 set (v1 card) -> CMD55. Otherwise ERROR code 2.
//    - CMD55 0x77 arg 0x00000000 crc 0x65. Flags bit7..1 all 0 -> ACMD41, otherwise ERROR code 3.
//    - ACMD41 0x69 arg 0x40000000 crc 0x77.
//      Flags==0x00 -> READY. Flags==0x01 -> retry++ and go to CMD55.
//      Retry reaching ACMD41_RETRIES -> ERROR code 3.
//    - CMD17 0x51 arg rd_addr crc 0xFF.
//      Flags==0x00 -> rd_data=cmd_data, rd_valid pulse, back to READY.
//      Otherwise ERROR code 5, with no rd_valid.
//  - ready=1 only in state READY. rd_req is accepted in READY only; it is ignored while busy or not ready.
//  - rd_req and init_start both high in READY: rd_req wins. init_start is ignored outside IDLE.
//  - ERROR holds until reset. cmd_start stays 0 there; error=1, ready=0.
//  - Reset mid-command: all outputs return to 0 asynchronously, which drops cmd_start.
//    The engine is reset by the same system reset.
//  - Counters are saturating: retry is 10 bits, timeout is 16 bits.
// STRUCTURE
//  - Package sd_pkg:
//    - typedef sd_cmd_t {idx, arg, crc}.
//    - Constants CMD0/CMD8/CMD55/ACMD41/CMD17 (sd_cmd_t).
//    - R1 bit positions, err_code enum.
//  - Sub-module sd_cmd_hs: generic ISSUE/WAIT_DONE/RELEASE handshake plus timeout.
//    The top-level FSM only selects the command and evaluates the result.
// TESTING
//  Bench uses a behavioural engine model: done 20 cycles after start; stays high until start falls.
//  1. Card model replies 0x01,0x01,(0x01 to CMD55, 0x01 to ACMD41)x3, then 0x00.
//     -> ready=1, 4 ACMD41 issued, error=0.
//  2. From READY: rd_req with rd_addr=0x00000200, model data 0xDEADBEEF.
//     -> cmd_args=0x200, cmd_number=0x51, one rd_valid with rd_data=0xDEADBEEF.
//  3. CMD0 reply 0xFF -> error=1, err_code=1, no further cmd_start.
//  4. Model never asserts done -> cmd_reset pulse after 65535 cycles, err_code=4.
//  5. ACMD41 always replies 0x01 with ACMD41_RETRIES=4 -> err_code=3 after exactly 4 ACMD41s.
//  6. reset asserted during CMD8 WAIT_DONE -> all outputs 0 immediately.
//     Re-init after release succeeds as in test 1.

Source files
------------

// File: rtl/sd_pkg.sv
// sd_pkg: shared types and constants for the SD SPI-mode init/read sequencer.
//  sd_cmd_t   command descriptor handed to the handshake block
//  CMD*       the fixed commands of the power-up and read sequence
//  R1 bits    bit positions inside the R1 response byte
//  err_code_t failure reasons reported on err_code
package sd_pkg;

  typedef struct packed {
    logic [5:0]  idx;   // command index; transmitted byte is 0x40|idx
    logic [31:0] arg;
    logic [7:0]  crc;   // CRC7<<1 | end bit
  } sd_cmd_t;

  localparam sd_cmd_t CMD0   = '{idx: 6'd0,  arg: 32'h0000_0000, crc: 8'h95};
  localparam sd_cmd_t CMD8   = '{idx: 6'd8,  arg: 32'h0000_01AA, crc: 8'h87};
  localparam sd_cmd_t CMD55  = '{idx: 6'd55, arg: 32'h0000_0000, crc: 8'h65};
  localparam sd_cmd_t ACMD41 = '{idx: 6'd41, arg: 32'h4000_0000, crc: 8'h77};
  localparam sd_cmd_t CMD17  = '{idx: 6'd17, arg: 32'h0000_0000, crc: 8'hFF};

  localparam int          R1_IDLE      = 0;
  localparam int          R1_ILLEGAL   = 2;
  localparam logic [7:0]  R1_IDLE_ONLY = 8'h01 << R1_IDLE;

  typedef enum logic [2:0] {
    ERR_NONE    = 3'd0,
    ERR_CMD0    = 3'd1,
    ERR_CMD8    = 3'd2,
    ERR_ACMD41  = 3'd3,
    ERR_TIMEOUT = 3'd4,
    ERR_CMD17   = 3'd5
  } err_code_t;

  function automatic logic [7:0] cmd_byte(input sd_cmd_t c);
    return {2'b01, c.idx};
  endfunction

endpackage

// File: rtl/sd_cmd_hs.sv
// sd_cmd_hs: one command round-trip with the command engine.
//  ISSUE puts the command on cmd_number/cmd_args/cmd_crc, WAIT_DONE holds
//  cmd_start until cmd_done, RELEASE drops cmd_start and waits for cmd_done
//  to fall. A cycle counter running through WAIT_DONE and RELEASE aborts the
//  command with a one-cycle cmd_reset.
// Ports:
//  go/cmd                 launch request (accepted only when idle)
//  res_valid/flags/data   one-cycle pulse with the latched engine response
//  tmo                    one-cycle pulse when the command timed out
//  cmd_* / cmd_done ...   engine interface
module sd_cmd_hs
  import sd_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        go,
  input  sd_cmd_t     cmd,
  output logic        res_valid,
  output logic [7:0]  res_flags,
  output logic [31:0] res_data,
  output logic        tmo,
  output logic [7:0]  cmd_number,
  output logic [31:0] cmd_args,
  output logic [7:0]  cmd_crc,
  output logic        cmd_start,
  output logic        cmd_reset,
  input  logic        cmd_done,
  input  logic [7:0]  cmd_flags,
  input  logic [31:0] cmd_data
);

  localparam logic [1:0] H_IDLE  = 2'd0;
  localparam logic [1:0] H_ISSUE = 2'd1;
  localparam logic [1:0] H_WAIT  = 2'd2;
  localparam logic [1:0] H_REL   = 2'd3;

  // tcnt counts completed waiting cycles; firing at TIMEOUT_CYCLES-1 makes
  // cmd_reset appear TIMEOUT_CYCLES cycles after cmd_start rose.
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

  logic [1:0]  hs;
  logic [15:0] tcnt;
  logic        expired;
  logic [15:0] tcnt_inc;

  assign expired  = (tcnt >= TMO_LAST);
  assign tcnt_inc = (tcnt == 16'hFFFF) ? tcnt : tcnt + 16'd1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hs         <= H_IDLE;
      tcnt       <= '0;
      res_valid  <= 1'b0;
      res_flags  <= '0;
      res_data   <= '0;
      tmo        <= 1'b0;
      cmd_number <= '0;
      cmd_args   <= '0;
      cmd_crc    <= '0;
      cmd_start  <= 1'b0;
      cmd_reset  <= 1'b0;
    end else begin
      res_valid <= 1'b0;
      tmo       <= 1'b0;
      cmd_reset <= 1'b0;
      case (hs)
        H_IDLE: if (go) begin
          cmd_number <= cmd_byte(cmd);
          cmd_args   <= cmd.arg;
          cmd_crc    <= cmd.crc;
          hs         <= H_ISSUE;
        end
        // fields have been stable for a cycle before start is raised
        H_ISSUE: begin
          cmd_start <= 1'b1;
          tcnt      <= '0;
          hs        <= H_WAIT;
        end
        H_WAIT: begin
          if (cmd_done) begin
            res_flags <= cmd_flags;
            res_data  <= cmd_data;
            cmd_start <= 1'b0;
            hs        <= H_REL;
          end else if (expired) begin
            cmd_start <= 1'b0;
            cmd_reset <= 1'b1;
            tmo       <= 1'b1;
            hs        <= H_IDLE;
          end else begin
            tcnt <= tcnt_inc;
          end
        end
        default: begin  // H_REL
          if (!cmd_done) begin
            res_valid <= 1'b1;
            hs        <= H_IDLE;
          end else if (expired) begin
            cmd_reset <= 1'b1;
            tmo       <= 1'b1;
            hs        <= H_IDLE;
          end else begin
            tcnt <= tcnt_inc;
          end
        end
      endcase
    end
  end

endmodule

// File: rtl/sd_init_seq.sv
// sd_init_seq: SD SPI-mode power-up sequencer and single-block read server.
//  Power-up: CMD0, CMD8, then CMD55/ACMD41 pairs until the card leaves idle.
//  Afterwards each accepted rd_req issues CMD17 and returns the data word.
// Ports:
//  clk, reset              clock, async active-high reset
//  init_start              rising edge in IDLE starts power-up
//  ready, error, err_code  status; error is sticky until reset
//  rd_req, rd_addr         read request, accepted only while ready
//  rd_busy, rd_valid, rd_data   read in flight / one-cycle result
//  cmd_*, cmd_done, cmd_flags, cmd_data   command engine interface
module sd_init_seq
  import sd_pkg::*;
#(
  parameter int ACMD41_RETRIES = 1000,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        init_start,
  output logic        ready,
  output logic        error,
  output logic [2:0]  err_code,
  input  logic        rd_req,
  input  logic [31:0] rd_addr,
  output logic        rd_busy,
  output logic        rd_valid,
  output logic [31:0] rd_data,
  output logic [7:0]  cmd_number,
  output logic [31:0] cmd_args,
  output logic [7:0]  cmd_crc,
  output logic        cmd_start,
  output logic        cmd_reset,
  input  logic        cmd_done,
  input  logic [7:0]  cmd_flags,
  input  logic [31:0] cmd_data
);

  // each command state means "that command is in flight in sd_cmd_hs"
  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_CMD0   = 3'd1;
  localparam logic [2:0] S_CMD8   = 3'd2;
  localparam logic [2:0] S_CMD55  = 3'd3;
  localparam logic [2:0] S_ACMD41 = 3'd4;
  localparam logic [2:0] S_READY  = 3'd5;
  localparam logic [2:0] S_CMD17  = 3'd6;
  localparam logic [2:0] S_ERROR  = 3'd7;

  localparam logic [9:0] RETRY_MAX = 10'(ACMD41_RETRIES);

  logic [2:0]  state, nxt_state;
  sd_cmd_t     cmd_sel, nxt_cmd;
  err_code_t   err_q, nxt_err;
  logic        go, launch, retry_inc, rd_ok, init_d;
  logic [9:0]  retry, retry_nxt;
  logic        res_valid, tmo;
  logic [7:0]  res_flags;
  logic [31:0] res_data;

  sd_cmd_hs #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_hs (
    .clk        (clk),
    .reset      (reset),
    .go         (go),
    .cmd        (cmd_sel),
    .res_valid  (res_valid),
    .res_flags  (res_flags),
    .res_data   (res_data),
    .tmo        (tmo),
    .cmd_number (cmd_number),
    .cmd_args   (cmd_args),
    .cmd_crc    (cmd_crc),
    .cmd_start  (cmd_start),
    .cmd_reset  (cmd_reset),
    .cmd_done   (cmd_done),
    .cmd_flags  (cmd_flags),
    .cmd_data   (cmd_data)
  );

  assign ready    = (state == S_READY);
  assign error    = (state == S_ERROR);
  assign rd_busy  = (state == S_CMD17);
  assign err_code = err_q;

  assign retry_nxt = (retry == 10'h3FF) ? retry : retry + 10'd1;

  always_comb begin
    nxt_state = state;
    nxt_cmd   = cmd_sel;
    nxt_err   = err_q;
    launch    = 1'b0;
    retry_inc = 1'b0;
    rd_ok     = 1'b0;
    case (state)
      S_IDLE: if (init_start && !init_d) begin
        nxt_state = S_CMD0;
        nxt_cmd   = CMD0;
        launch    = 1'b1;
      end
      S_READY: if (rd_req) begin
        nxt_state   = S_CMD17;
        nxt_cmd     = CMD17;
        nxt_cmd.arg = rd_addr;
        launch      = 1'b1;
      end
      S_ERROR: ;
      default: begin
        if (tmo) begin
          nxt_state = S_ERROR;
          nxt_err   = ERR_TIMEOUT;
        end else if (res_valid) begin
          // failure unless the branch below moves on
          nxt_state = S_ERROR;
          case (state)
            S_CMD0:
              if (res_flags == R1_IDLE_ONLY) begin
                nxt_state = S_CMD8; nxt_cmd = CMD8; launch = 1'b1;
              end else nxt_err = ERR_CMD0;
            // illegal-command reply marks a v1 card, which skips CMD8
            S_CMD8:
              if (res_flags == R1_IDLE_ONLY || res_flags[R1_ILLEGAL]) begin
                nxt_state = S_CMD55; nxt_cmd = CMD55; launch = 1'b1;
              end else nxt_err = ERR_CMD8;
            S_CMD55:
              if (res_flags[7:1] == 7'd0) begin
                nxt_state = S_ACMD41; nxt_cmd = ACMD41; launch = 1'b1;
              end else nxt_err = ERR_ACMD41;
            S_ACMD41:
              if (res_flags == 8'h00) begin
                nxt_state = S_READY;
              end else if (res_flags == R1_IDLE_ONLY && retry_nxt < RETRY_MAX) begin
                retry_inc = 1'b1;
                nxt_state = S_CMD55; nxt_cmd = CMD55; launch = 1'b1;
              end else nxt_err = ERR_ACMD41;
            S_CMD17:
              if (res_flags == 8'h00) begin
                nxt_state = S_READY; rd_ok = 1'b1;
              end else nxt_err = ERR_CMD17;
            default: ;
          endcase
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= S_IDLE;
      cmd_sel  <= '0;
      err_q    <= ERR_NONE;
      go       <= 1'b0;
      retry    <= '0;
      init_d   <= 1'b0;
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      state    <= nxt_state;
      cmd_sel  <= nxt_cmd;
      err_q    <= nxt_err;
      go       <= launch;
      init_d   <= init_start;
      rd_valid <= rd_ok;
      if (state == S_IDLE && launch) retry <= '0;
      else if (retry_inc)            retry <= retry_nxt;
      if (rd_ok) rd_data <= res_data;
    end
  end

endmodule

// File: tb/tb_sd_init_seq.sv
// tb_sd_init_seq: randomized scoreboard bench for sd_init_seq with a
// behavioural command engine and scripted card replies.
module tb_sd_init_seq;

  localparam int RETRIES = 4;
  localparam int TMO     = 65535;

  logic        clk = 1'b0, reset = 1'b1, init_start = 1'b0, rd_req = 1'b0;
  logic [31:0] rd_addr = '0;
  logic        ready, error, rd_busy, rd_valid, cmd_start, cmd_reset;
  logic [2:0]  err_code;
  logic [31:0] rd_data, cmd_args;
  logic [7:0]  cmd_number, cmd_crc;
  logic        cmd_done;
  logic [7:0]  cmd_flags;
  logic [31:0] cmd_data;

  sd_init_seq #(.ACMD41_RETRIES(RETRIES), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .reset(reset), .init_start(init_start), .ready(ready),
    .error(error), .err_code(err_code), .rd_req(rd_req), .rd_addr(rd_addr),
    .rd_busy(rd_busy), .rd_valid(rd_valid), .rd_data(rd_data),
    .cmd_number(cmd_number), .cmd_args(cmd_args), .cmd_crc(cmd_crc),
    .cmd_start(cmd_start), .cmd_reset(cmd_reset), .cmd_done(cmd_done),
    .cmd_flags(cmd_flags), .cmd_data(cmd_data)
  );

  always #5 clk = ~clk;

  int checks = 0, failures = 0;
  int start_cnt = 0, acmd_cnt = 0, rdv_cnt = 0;
  bit no_done = 1'b0;
  logic [7:0]  script[$];
  logic [7:0]  reply_q[$];
  logic [31:0] data_q[$];
  logic [47:0] exp_cmd_q[$];
  logic [31:0] exp_rd_q[$];
  logic        mon_prev;
  logic [47:0] mon_e;
  logic [31:0] mon_d;
  int          ecnt;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- engine + card model ----------------
  function automatic logic [7:0] next_reply();
    if (reply_q.size() == 0) return 8'hFF;
    return reply_q.pop_front();
  endfunction

  function automatic logic [31:0] next_data();
    if (data_q.size() == 0) return 32'h0;
    return data_q.pop_front();
  endfunction

  // done 20 cycles after start, held until start falls
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      cmd_done  <= 1'b0;
      cmd_flags <= 8'h00;
      cmd_data  <= 32'h0;
      ecnt      <= 0;
    end else if (cmd_reset || !cmd_start) begin
      cmd_done <= 1'b0;
      ecnt     <= 0;
    end else if (!cmd_done && !no_done) begin
      if (ecnt == 19) begin
        cmd_done  <= 1'b1;
        cmd_flags <= next_reply();
        if (cmd_number == 8'h51) cmd_data <= next_data();
      end else begin
        ecnt <= ecnt + 1;
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  initial begin
    mon_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (cmd_start && !mon_prev) begin
        start_cnt++;
        if (cmd_number == 8'h69) acmd_cnt++;
        if (exp_cmd_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_cmd: got 0x%0h expected none", {cmd_number, cmd_args, cmd_crc});
        end else begin
          mon_e = exp_cmd_q.pop_front();
          check("cmd_fields", 64'({cmd_number, cmd_args, cmd_crc}), 64'(mon_e));
        end
      end
      mon_prev = cmd_start;
      if (rd_valid) begin
        rdv_cnt++;
        if (exp_rd_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_rd_valid: got 0x%0h expected none", rd_data);
        end else begin
          mon_d = exp_rd_q.pop_front();
          check("rd_data", 64'(rd_data), 64'(mon_d));
        end
      end
    end
  end

  // ---------------- reference model ----------------
  // Walks the card script through the sequence rules, predicting the
  // command list, the final outcome (0 ready, else error code) and the
  // number of ACMD41s.
  task automatic plan(output int outcome, output int nacmd);
    int step, retries, i;
    logic [7:0] f;
    step = 0; retries = 0; i = 0; outcome = -1; nacmd = 0;
    foreach (script[k]) reply_q.push_back(script[k]);
    while (outcome < 0) begin
      f = (i < script.size()) ? script[i] : 8'hFF;
      i++;
      case (step)
        0: begin
          exp_cmd_q.push_back({8'h40, 32'h0, 8'h95});
          if (f == 8'h01) step = 8; else outcome = 1;
        end
        8: begin
          exp_cmd_q.push_back({8'h48, 32'h1AA, 8'h87});
          if (f == 8'h01 || f[2]) step = 55; else outcome = 2;
        end
        55: begin
          exp_cmd_q.push_back({8'h77, 32'h0, 8'h65});
          if (f[7:1] == 7'd0) step = 41; else outcome = 3;
        end
        default: begin
          exp_cmd_q.push_back({8'h69, 32'h4000_0000, 8'h77});
          nacmd++;
          if (f == 8'h00) outcome = 0;
          else if (f == 8'h01) begin
            retries++;
            if (retries >= RETRIES) outcome = 3; else step = 55;
          end else outcome = 3;
        end
      endcase
    end
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic do_reset();
    reset = 1'b1; init_start = 1'b0; rd_req = 1'b0; no_done = 1'b0;
    repeat (3) @(negedge clk);
    exp_cmd_q.delete(); reply_q.delete(); data_q.delete();
    exp_rd_q.delete(); script.delete();
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic run_init(input string tag);
    int outcome, nacmd, base, n;
    plan(outcome, nacmd);
    base = acmd_cnt;
    init_start = 1'b1;
    n = 0;
    while (!(ready || error) && n < 5000) begin @(negedge clk); n++; end
    init_start = 1'b0;
    @(negedge clk);
    if (outcome == 0) begin
      check({tag, "_ready"}, 64'(ready), 64'(1));
      check({tag, "_error"}, 64'(error), 64'(0));
    end else begin
      check({tag, "_error"}, 64'(error), 64'(1));
      check({tag, "_err_code"}, 64'(err_code), 64'(outcome));
      check({tag, "_ready"}, 64'(ready), 64'(0));
    end
    check({tag, "_acmd41_count"}, 64'(acmd_cnt - base), 64'(nacmd));
    check({tag, "_cmds_left"}, 64'(exp_cmd_q.size()), 64'(0));
  endtask

  task automatic do_read(input logic [31:0] addr, input logic [31:0] data, input logic [7:0] flags);
    int n, rv0;
    n = 0; rv0 = rdv_cnt;
    reply_q.push_back(flags);
    data_q.push_back(data);
    exp_cmd_q.push_back({8'h51, addr, 8'hFF});
    if (flags == 8'h00) exp_rd_q.push_back(data);
    rd_addr = addr; rd_req = 1'b1;
    @(negedge clk);
    rd_req = 1'b0;
    check("rd_busy_accept", 64'(rd_busy), 64'(1));
    check("ready_while_busy", 64'(ready), 64'(0));
    // a second request while busy must be ignored
    rd_addr = ~addr; rd_req = 1'b1;
    @(negedge clk);
    rd_req = 1'b0;
    while (rd_busy && n < 500) begin @(negedge clk); n++; end
    @(negedge clk);
    if (flags == 8'h00) begin
      check("rd_back_ready", 64'(ready), 64'(1));
      check("rd_valid_count", 64'(rdv_cnt - rv0), 64'(1));
    end else begin
      check("cmd17_error", 64'(error), 64'(1));
      check("cmd17_err_code", 64'(err_code), 64'(5));
      check("cmd17_no_rd_valid", 64'(rdv_cnt - rv0), 64'(0));
    end
    check("rd_cmds_left", 64'(exp_cmd_q.size()), 64'(0));
  endtask

  task automatic rand_init_script();
    int r;
    r = $urandom_range(0, 2);
    script.push_back(8'h01);
    script.push_back(($urandom_range(0, 1) == 1) ? 8'h05 : 8'h01);
    repeat (r) begin script.push_back(8'h01); script.push_back(8'h01); end
    script.push_back(8'h01);
    script.push_back(8'h00);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int n, snap, o, na, base;
    repeat (2) @(negedge clk);
    check("reset_status", 64'({ready, error, err_code, rd_busy, rd_valid, cmd_start, cmd_reset}), 64'(0));
    check("reset_cmd", 64'({cmd_number, cmd_args, cmd_crc}), 64'(0));
    check("reset_rd_data", 64'(rd_data), 64'(0));
    reset = 1'b0;
    @(negedge clk);

    // power-up with three ACMD41 retries
    script = '{8'h01, 8'h01, 8'h01, 8'h01, 8'h01, 8'h01, 8'h01, 8'h01, 8'h01, 8'h00};
    run_init("init");

    // reads: fixed, random, then a failing CMD17
    do_read(32'h0000_0200, 32'hDEAD_BEEF, 8'h00);
    repeat (4) begin
      repeat ($urandom_range(0, 5)) @(negedge clk);
      do_read($urandom, $urandom, 8'h00);
    end
    do_read($urandom, $urandom, 8'h04);

    // CMD0 failure: no further commands
    do_reset();
    script = '{8'hFF};
    run_init("cmd0_err");
    snap = start_cnt;
    repeat (50) @(negedge clk);
    check("no_start_after_err", 64'(start_cnt - snap), 64'(0));
    check("err_start_low", 64'(cmd_start), 64'(0));

    // CMD8 rejection
    do_reset();
    script = '{8'h01, 8'h00};
    run_init("cmd8_err");

    // ACMD41 never leaves idle
    do_reset();
    script = '{8'h01, 8'h01, 8'h01, 8'h01, 8'h01, 8'h01, 8'h01, 8'h01, 8'h01, 8'h01, 8'h01, 8'h01};
    run_init("acmd41_exhaust");

    // randomized successful power-ups with a read each
    repeat (2) begin
      do_reset();
      rand_init_script();
      run_init("rand_init");
      do_read($urandom, $urandom, 8'h00);
    end

    // reset during CMD8 wait, then re-init
    do_reset();
    script = '{8'h01, 8'h01, 8'h01, 8'h01, 8'h01, 8'h01, 8'h01, 8'h01, 8'h01, 8'h00};
    plan(o, na);
    base = start_cnt;
    init_start = 1'b1;
    n = 0;
    while (start_cnt < base + 2 && n < 500) begin @(negedge clk); n++; end
    check("cmd8_in_flight", 64'(cmd_number), 64'(8'h48));
    repeat (5) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("midreset_status", 64'({ready, error, err_code, rd_busy, rd_valid, cmd_start, cmd_reset}), 64'(0));
    check("midreset_cmd", 64'({cmd_number, cmd_args, cmd_crc}), 64'(0));
    init_start = 1'b0;
    do_reset();
    script = '{8'h01, 8'h01, 8'h01, 8'h01, 8'h01, 8'h01, 8'h01, 8'h01, 8'h01, 8'h00};
    run_init("reinit");

    // engine never answers: timeout on CMD0
    do_reset();
    no_done = 1'b1;
    exp_cmd_q.push_back({8'h40, 32'h0, 8'h95});
    init_start = 1'b1;
    n = 0;
    while (!cmd_start && n < 20) begin @(negedge clk); n++; end
    n = 0;
    while (!cmd_reset && n < 70000) begin @(negedge clk); n++; end
    check("tmo_cycles", 64'(n), 64'(65535));
    @(negedge clk);
    check("tmo_reset_pulse", 64'(cmd_reset), 64'(0));
    check("tmo_err_code", 64'(err_code), 64'(4));
    check("tmo_error", 64'(error), 64'(1));
    check("tmo_start_low", 64'(cmd_start), 64'(0));
    init_start = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #950000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
